// File: rtl/popcount_seq.sv
// popcount_seq: counts the ones in each accepted word CHUNK_WIDTH bits per cycle and keeps a saturating running total.
// Ports: clk_in/rst_in (sync active-high reset); valid_in, number_in, accumulate_in accept a word when ready_out;
// clear_acc_in zeroes the total; count_out/count_valid_out report each finished word; total_out/total_overflow_out
// hold the saturating total and its sticky saturation flag.
module popcount_seq #(
    parameter int NUMBER_WIDTH = 32,
    parameter int CHUNK_WIDTH  = 8,
    parameter int COUNT_WIDTH  = $clog2(NUMBER_WIDTH + 1),
    parameter int ACC_WIDTH    = 16
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    valid_in,
    input  logic [NUMBER_WIDTH-1:0] number_in,
    input  logic                    accumulate_in,
    input  logic                    clear_acc_in,
    output logic                    ready_out,
    output logic [COUNT_WIDTH-1:0]  count_out,
    output logic                    count_valid_out,
    output logic [ACC_WIDTH-1:0]    total_out,
    output logic                    total_overflow_out
);
    localparam int N = NUMBER_WIDTH / CHUNK_WIDTH;
    localparam int IDX_WIDTH = N > 1 ? $clog2(N) : 1;
    localparam int SUM_WIDTH = ACC_WIDTH > COUNT_WIDTH ? ACC_WIDTH + 1 : COUNT_WIDTH + 1;
    localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(N - 1);
    localparam logic [SUM_WIDTH-1:0] SAT = {{(SUM_WIDTH - ACC_WIDTH){1'b0}}, {ACC_WIDTH{1'b1}}};
    typedef enum logic {IDLE, COUNT} state_t;
    state_t state, state_next;
    logic [NUMBER_WIDTH-1:0] shreg;
    logic [COUNT_WIDTH-1:0] partial, chunk_pc, partial_sum;
    logic [IDX_WIDTH-1:0] idx;
    logic acc_lat, accept, done;
    logic [SUM_WIDTH-1:0] sum;
    always_comb begin
        chunk_pc = '0;
        for (int i = 0; i < CHUNK_WIDTH; i++)
            chunk_pc = chunk_pc + COUNT_WIDTH'(shreg[i]);
    end
    always_comb begin
        ready_out   = state == IDLE;
        accept      = valid_in && ready_out;
        done        = state == COUNT && idx == LAST;
        partial_sum = partial + chunk_pc;
        // A clear on the completing edge restarts the total from this word's count.
        sum         = (clear_acc_in ? '0 : SUM_WIDTH'(total_out)) + SUM_WIDTH'(partial_sum);
        state_next  = accept ? COUNT : done ? IDLE : state;
    end
    always_ff @(posedge clk_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_next;
    end
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            shreg              <= '0;
            partial            <= '0;
            idx                <= '0;
            acc_lat            <= 1'b0;
            count_out          <= '0;
            count_valid_out    <= 1'b0;
            total_out          <= '0;
            total_overflow_out <= 1'b0;
        end else begin
            count_valid_out <= done;
            if (accept) begin
                shreg   <= number_in;
                acc_lat <= accumulate_in;
                partial <= '0;
                idx     <= '0;
            end else if (state == COUNT) begin
                partial <= partial_sum;
                shreg   <= shreg >> CHUNK_WIDTH;
                idx     <= idx + IDX_WIDTH'(1);
            end
            if (done) count_out <= partial_sum;
            if (done && acc_lat) begin
                total_out          <= sum > SAT ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
                total_overflow_out <= sum > SAT || (!clear_acc_in && total_overflow_out);
            end else if (clear_acc_in) begin
                total_out          <= '0;
                total_overflow_out <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_popcount_seq.sv
// tb_popcount_seq: directed checks of popcount_seq with a 16-bit and a 6-bit total driven from shared inputs.
module tb_popcount_seq;
    logic clk = 1'b0;
    logic rst, valid, acc, clr;
    logic [31:0] number;
    logic ready_m, valid_m, ovf_m, ready_s, valid_s, ovf_s;
    logic [5:0] count_m, count_s;
    logic [15:0] total_m;
    logic [5:0] total_s;
    int n_total = 0;
    int n_pass = 0;
    logic [5:0] prev_count;
    always #5 clk = ~clk;
    popcount_seq u_main (
        .clk_in(clk), .rst_in(rst), .valid_in(valid), .number_in(number),
        .accumulate_in(acc), .clear_acc_in(clr), .ready_out(ready_m),
        .count_out(count_m), .count_valid_out(valid_m),
        .total_out(total_m), .total_overflow_out(ovf_m)
    );
    popcount_seq #(.ACC_WIDTH(6)) u_sat (
        .clk_in(clk), .rst_in(rst), .valid_in(valid), .number_in(number),
        .accumulate_in(acc), .clear_acc_in(clr), .ready_out(ready_s),
        .count_out(count_s), .count_valid_out(valid_s),
        .total_out(total_s), .total_overflow_out(ovf_s)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic check_totals(input int tm, input int om, input int ts, input int os);
        check("total_main", 32'(total_m), tm);
        check("ovf_main", 32'(ovf_m), om);
        check("total_sat", 32'(total_s), ts);
        check("ovf_sat", 32'(ovf_s), os);
    endtask
    task automatic run_word(input logic [31:0] w, input logic a, input logic c, input int exp_cnt,
                            input int tm, input int om, input int ts, input int os);
        number = w;
        acc    = a;
        valid  = 1'b1;
        tick();
        check("busy_ready", 32'(ready_m), 0);
        check("accept_no_pulse", 32'(valid_m), 0);
        number = ~w;
        acc    = ~a;
        for (int k = 1; k < 4; k++) begin
            tick();
            check("busy_ready", 32'(ready_m | ready_s), 0);
            check("busy_no_pulse", 32'(valid_m | valid_s), 0);
            check("count_hold", 32'(count_m), 32'(prev_count));
        end
        clr = c;
        tick();
        clr = 1'b0;
        check("pulse_main", 32'(valid_m), 1);
        check("pulse_sat", 32'(valid_s), 1);
        check("count_main", 32'(count_m), exp_cnt);
        check("count_sat", 32'(count_s), exp_cnt);
        check("done_ready", 32'(ready_m), 1);
        check_totals(tm, om, ts, os);
        prev_count = 6'(exp_cnt);
    endtask
    initial begin
        rst = 1'b1; valid = 1'b0; acc = 1'b0; clr = 1'b0; number = '0;
        prev_count = '0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_ready", 32'(ready_m), 1);
        check("reset_count", 32'(count_m), 0);
        check("reset_pulse", 32'(valid_m), 0);
        check_totals(0, 0, 0, 0);
        tick();
        check("idle_ready", 32'(ready_m), 1);
        check("idle_pulse", 32'(valid_m), 0);
        run_word(32'hFFFF_FFFF, 1'b0, 1'b0, 32, 0, 0, 0, 0);
        run_word(32'h0000_0000, 1'b0, 1'b0, 0, 0, 0, 0, 0);
        run_word(32'h8000_0001, 1'b0, 1'b0, 2, 0, 0, 0, 0);
        run_word(32'hF0F0_F0F0, 1'b1, 1'b0, 16, 16, 0, 16, 0);
        run_word(32'hF0F0_F0F0, 1'b1, 1'b0, 16, 32, 0, 32, 0);
        run_word(32'hF0F0_F0F0, 1'b1, 1'b0, 16, 48, 0, 48, 0);
        run_word(32'hF0F0_F0F0, 1'b0, 1'b0, 16, 48, 0, 48, 0);
        valid = 1'b0;
        tick();
        check("pulse_drop", 32'(valid_m), 0);
        check("count_after", 32'(count_m), 16);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_totals(0, 0, 0, 0);
        run_word(32'hFFFF_FFFF, 1'b1, 1'b0, 32, 32, 0, 32, 0);
        run_word(32'hFFFF_FFFF, 1'b1, 1'b0, 32, 64, 0, 63, 1);
        run_word(32'h0000_0000, 1'b0, 1'b0, 0, 64, 0, 63, 1);
        run_word(32'h0000_000F, 1'b1, 1'b1, 4, 4, 0, 4, 0);
        valid = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_totals(0, 0, 0, 0);
        run_word(32'h0000_03FF, 1'b1, 1'b0, 10, 10, 0, 10, 0);
        number = 32'hFFFF_FFFF;
        acc    = 1'b1;
        valid  = 1'b1;
        tick();
        valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        prev_count = '0;
        check("abort_pulse", 32'(valid_m | valid_s), 0);
        check("abort_ready", 32'(ready_m), 1);
        check("abort_count", 32'(count_m), 0);
        check_totals(0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("abort_quiet", 32'(valid_m | valid_s), 0);
            check("abort_total", 32'(total_m), 0);
        end
        run_word(32'h0000_0007, 1'b0, 1'b0, 3, 0, 0, 0, 0);
        valid = 1'b0;
        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/popcount_seq.md
POPCOUNT_SEQ -- requirements
Module: popcount_seq

Interface
REQ-001 Parameter: NUMBER_WIDTH, default 32, width of each input word; SHALL be a positive multiple of CHUNK_WIDTH.
REQ-002 Parameter: CHUNK_WIDTH, default 8, bits counted per clock cycle.
REQ-003 Parameter: COUNT_WIDTH, default $clog2(NUMBER_WIDTH+1), width of the per-word count.
REQ-004 Parameter: ACC_WIDTH, default 16, width of the running total.
REQ-005 Clocking: one clock; reset is synchronous and active-high.
REQ-006 clk_in  input  1  sole clock; all state updates on the rising edge.
REQ-007 rst_in  input  1  synchronous active-high reset.
REQ-008 valid_in  input  1  number_in and accumulate_in are valid this cycle.
REQ-009 number_in  input  NUMBER_WIDTH  word to count.
REQ-010 accumulate_in  input  1  add this word's count into total_out on completion.
REQ-011 clear_acc_in  input  1  clear total_out and total_overflow_out.
REQ-012 ready_out  output  1  block can accept a word.
REQ-013 count_out  output  COUNT_WIDTH  number of ones in the last completed word.
REQ-014 count_valid_out  output  1  one-cycle pulse: count_out has just been updated.
REQ-015 total_out  output  ACC_WIDTH  saturating running total.
REQ-016 total_overflow_out  output  1  sticky flag: total_out has saturated.

Function
REQ-017 The block SHALL use two states: IDLE and COUNT; ready_out = (state == IDLE), driven combinationally from state.
REQ-018 Accept: a word is accepted on a rising edge where valid_in && ready_out; on that edge the block latches number_in into a shift register, latches accumulate_in, clears the partial count and enters COUNT.
REQ-019 valid_in while in COUNT SHALL be ignored, with no effect on the word in progress.
REQ-020 COUNT: on each edge the block adds the popcount of the low CHUNK_WIDTH bits to the partial count, shifts the register right by CHUNK_WIDTH and increments the chunk index.
REQ-021 Latency: with N = NUMBER_WIDTH/CHUNK_WIDTH, the final chunk is added on the Nth edge after the accept edge. On that edge the block SHALL register count_out as the full popcount, set count_valid_out=1 for exactly one cycle and return to IDLE.
REQ-022 Throughput: the earliest next accept SHALL be the (N+1)th edge after the previous accept.
REQ-023 count_out SHALL hold its value until the next completion; count_valid_out SHALL be 0 in all other cycles.
REQ-024 Width: the partial count SHALL be COUNT_WIDTH bits and SHALL never wrap, because COUNT_WIDTH holds the value NUMBER_WIDTH.
REQ-025 Accumulate on completion (latched accumulate_in=1): total_out = min(total_out + count, 2^ACC_WIDTH-1), computed at ACC_WIDTH+1 bits.
REQ-026 Saturation: if the sum exceeds 2^ACC_WIDTH-1, total_overflow_out SHALL be set to 1 and SHALL stay at 1 until cleared.
REQ-027 No accumulate: with latched accumulate_in=0, total_out and total_overflow_out SHALL be unchanged on completion.
REQ-028 Clear: clear_acc_in=1 SHALL zero total_out and total_overflow_out on that edge, in any state.
REQ-029 Clear and accumulating completion on the same edge: total_out = count of the completing word, total_overflow_out = 0.
REQ-030 Degenerate case CHUNK_WIDTH == NUMBER_WIDTH: N = 1, so the valid pulse SHALL occur on the first edge after accept.

Reset
REQ-031 On rst_in=1 the block SHALL enter IDLE and set count_out=0, count_valid_out=0, total_out=0, total_overflow_out=0, and clear the shift register, partial count and chunk index; ready_out=1 in the cycle after the reset edge.
REQ-032 rst_in SHALL take priority over accept, COUNT progress, completion and clear_acc_in.
REQ-033 Reset during COUNT SHALL abort the word with no count_valid_out pulse and no change to total_out beyond the reset value.

Verification (NUMBER_WIDTH=32, CHUNK_WIDTH=8, N=4)
REQ-034 Reset, then idle: ready_out=1; count_out, count_valid_out, total_out and total_overflow_out all 0.
REQ-035 Accept 32'hFFFF_FFFF, then 32'h0000_0000, then 32'h8000_0001, each back-to-back at max rate: count_out = 32, 0, 2; each pulse arrives 4 edges after its accept; ready_out=0 for the 4 COUNT cycles; valid_in held high while busy is ignored.
REQ-036 Three words of 32'hF0F0_F0F0 with accumulate_in=1, then one word with accumulate_in=0: total_out = 16, 32, 48, 48.
REQ-037 ACC_WIDTH=6: two accumulating words of 32'hFFFF_FFFF give total_out = 32, then 63 with total_overflow_out=1. Then clear_acc_in on the completion edge of a third accumulating word of 32'h0000_000F gives total_out=4, total_overflow_out=0.
REQ-038 Assert rst_in on the 2nd COUNT edge of 32'hFFFF_FFFF with total_out=10: no count_valid_out pulse, total_out=0, ready_out=1. The next word 32'h0000_0007 yields count_out=3.
